game_sequencer: RTL

Top-level game state controller for the 800x600 plane/road demo. Derives a once-per-frame tick from the pixel counters and sequences the logo, start, play, pause, respawn, game-over and finish phases from the centre button and a collision flag. Drives the `display_text` enables and the text refresh tick, gates object movement, and keeps lives and distance. Sits in `game_top` between the pixel counters and the object/text/render logic.

---
 rtl/game_pkg.sv | 27 ++
 rtl/game_sequencer_if.sv | 32 +++
 rtl/game_frame_tick.sv | 38 +++
 rtl/game_sequencer.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the game sequencer: state encoding and
// the pixel-counter positions that mark frame and text-refresh events.
package game_pkg;

  typedef enum logic [2:0] {
    LOGO    = 3'd0,
    START   = 3'd1,
    PLAY    = 3'd2,
    PAUSE   = 3'd3,
    RESPAWN = 3'd4,
    OVER    = 3'd5,
    FINISH  = 3'd6
  } game_state_t;

  localparam logic [9:0] H_LAST            = 10'd799;
  localparam logic [9:0] V_LAST            = 10'd599;
  localparam logic [9:0] TEXT_REFRESH_LINE = 10'd481;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Bundle of pixel-position, player-input and game-status signals exchanged
// between the game sequencer (slave) and its surroundings (master).
interface game_sequencer_if;

  logic [10:0]               h_coord;
  logic [9:0]                v_coord;
  logic                      button_c;
  logic                      collision;
  game_pkg::game_state_t     state;
  logic                      logo_active;
  logic                      start_en;
  logic                      over_en;
  logic                      finish_en;
  logic                      pause;
  logic                      move_en;
  logic                      refresh_tick;
  logic [1:0]                lives_left;
  logic [15:0]               distance;

  modport master (
    output h_coord, v_coord, button_c, collision,
    input  state, logo_active, start_en, over_en, finish_en, pause,
           move_en, refresh_tick, lives_left, distance
  );

  modport slave (
    input  h_coord, v_coord, button_c, collision,
    output state, logo_active, start_en, over_en, finish_en, pause,
           move_en, refresh_tick, lives_left, distance
  );

endinterface

// File: rtl/game_frame_tick.sv
// Decodes the pixel counters into a once-per-frame tick and the text
// refresh tick, each registered and high for exactly one cycle.
module game_frame_tick
  import game_pkg::*;
(
  input  logic        pixel_clk,
  input  logic        rst_n,
  input  logic [10:0] i_h_coord,
  input  logic [9:0]  i_v_coord,
  output logic        o_frame_tick,
  output logic        o_refresh_tick
);

  logic r_frame_tick;
  logic r_refresh_tick;
  logic w_frame_hit;
  logic w_refresh_hit;
  logic w_unused_hbit;

  // Only the low ten column bits are meaningful for an 800-wide line.
  assign w_unused_hbit = i_h_coord[10];
  assign w_frame_hit   = (i_h_coord[9:0] == H_LAST) && (i_v_coord == V_LAST);
  assign w_refresh_hit = (i_h_coord[9:0] == 10'd0) && (i_v_coord == TEXT_REFRESH_LINE);

  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      r_frame_tick   <= 1'b0;
      r_refresh_tick <= 1'b0;
    end else begin
      r_frame_tick   <= w_frame_hit;
      r_refresh_tick <= w_refresh_hit;
    end
  end

  assign o_frame_tick   = r_frame_tick;
  assign o_refresh_tick = r_refresh_tick;

endmodule

// File: rtl/game_sequencer.sv
// Frame-paced game state machine with lives and distance tracking.
// Define GAME_PAUSE_EN to enable the PAUSE state toggled by the centre button.
module game_sequencer
  import game_pkg::*;
#(
  parameter int unsigned LOGO_FRAMES    = 120,
  parameter int unsigned RESPAWN_FRAMES = 60,
  parameter int unsigned HOLD_FRAMES    = 180,
  parameter int unsigned FINISH_DIST    = 3600,
  parameter int unsigned LIVES          = 3
) (
  input  logic            pixel_clk,
  input  logic            rst_n,
  game_sequencer_if.slave bus
);

  localparam logic [7:0]  LOGO_LAST    = 8'(LOGO_FRAMES - 1);
  localparam logic [7:0]  RESPAWN_LAST = 8'(RESPAWN_FRAMES - 1);
  localparam logic [16:0] FINISH_D     = 17'(FINISH_DIST);
  localparam logic [1:0]  LIVES_INIT   = 2'(LIVES);

  game_state_t r_state;
  logic        r_logo_active;
  logic        r_start_en;
  logic        r_over_en;
  logic        r_finish_en;
  logic        r_move_en;
  logic [1:0]  r_lives;
  logic [15:0] r_distance;
  logic [7:0]  r_hold_cnt;
  logic        r_btn_d;
  logic        r_press_pend;
`ifdef GAME_PAUSE_EN
  logic        r_pause;
`endif

  logic        w_frame_tick;
  logic        w_refresh_tick;
  logic        w_press;
  logic [16:0] w_dist_inc;
  logic        w_finish_hit;
  game_state_t w_state_nxt;
  logic [1:0]  w_lives_nxt;
  logic [15:0] w_dist_nxt;
  logic [7:0]  w_hold_nxt;
  logic        w_move_nxt;
  logic        w_pend_nxt;

  game_frame_tick u_frame_tick (
    .pixel_clk      (pixel_clk),
    .rst_n          (rst_n),
    .i_h_coord      (bus.h_coord),
    .i_v_coord      (bus.v_coord),
    .o_frame_tick   (w_frame_tick),
    .o_refresh_tick (w_refresh_tick)
  );

  assign w_press      = bus.button_c & ~r_btn_d;
  assign w_dist_inc   = {1'b0, r_distance} + 17'd1;
  // A zero finish distance turns the finish line off entirely.
  assign w_finish_hit = (FINISH_DIST != 0) && (w_dist_inc == FINISH_D);

  always_comb begin
    w_state_nxt = r_state;
    w_lives_nxt = r_lives;
    w_dist_nxt  = r_distance;
    w_hold_nxt  = r_hold_cnt;
    w_move_nxt  = 1'b0;
    w_pend_nxt  = r_press_pend | w_press;

    if (w_frame_tick) begin
      // The tick consumes the older pending press; a same-cycle press waits.
      w_pend_nxt = w_press;
      w_hold_nxt = sat_inc8(r_hold_cnt);

      unique case (r_state)
        LOGO: begin
          if (r_hold_cnt == LOGO_LAST) w_state_nxt = START;
        end
        START: begin
          if (r_press_pend) begin
            w_state_nxt = PLAY;
            w_lives_nxt = LIVES_INIT;
            w_dist_nxt  = 16'd0;
          end
        end
        PLAY: begin
          if (bus.collision && (r_lives <= 2'd1)) begin
            w_state_nxt = OVER;
            w_lives_nxt = 2'd0;
          end else if (bus.collision) begin
            w_state_nxt = RESPAWN;
            w_lives_nxt = r_lives - 2'd1;
          end else if (w_finish_hit) begin
            w_state_nxt = FINISH;
            w_dist_nxt  = w_dist_inc[15:0];
`ifdef GAME_PAUSE_EN
          end else if (r_press_pend) begin
            w_state_nxt = PAUSE;
`endif
          end else begin
            w_dist_nxt = sat_inc16(r_distance);
            w_move_nxt = 1'b1;
          end
        end
        PAUSE: begin
          if (r_press_pend) w_state_nxt = PLAY;
        end
        RESPAWN: begin
          if (r_hold_cnt == RESPAWN_LAST) w_state_nxt = PLAY;
        end
        OVER, FINISH: begin
          if (r_press_pend && (32'(r_hold_cnt) >= HOLD_FRAMES)) w_state_nxt = START;
        end
        default: w_state_nxt = LOGO;
      endcase

      if (w_state_nxt != r_state) w_hold_nxt = 8'd0;
    end
  end

  // Status flags are registered from the next state so they move with it.
  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      r_state       <= LOGO;
      r_logo_active <= 1'b1;
      r_start_en    <= 1'b0;
      r_over_en     <= 1'b0;
      r_finish_en   <= 1'b0;
      r_move_en     <= 1'b0;
      r_lives       <= 2'd0;
      r_distance    <= 16'd0;
      r_hold_cnt    <= 8'd0;
      r_btn_d       <= 1'b0;
      r_press_pend  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_logo_active <= (w_state_nxt == LOGO);
      r_start_en    <= (w_state_nxt == START);
      r_over_en     <= (w_state_nxt == OVER);
      r_finish_en   <= (w_state_nxt == FINISH);
      r_move_en     <= w_move_nxt;
      r_lives       <= w_lives_nxt;
      r_distance    <= w_dist_nxt;
      r_hold_cnt    <= w_hold_nxt;
      r_btn_d       <= bus.button_c;
      r_press_pend  <= w_pend_nxt;
    end
  end

`ifdef GAME_PAUSE_EN
  always_ff @(posedge pixel_clk) begin
    if (!rst_n) r_pause <= 1'b0;
    else        r_pause <= (w_state_nxt == PAUSE);
  end
  assign bus.pause = r_pause;
`else
  assign bus.pause = 1'b0;
`endif

  assign bus.state        = r_state;
  assign bus.logo_active  = r_logo_active;
  assign bus.start_en     = r_start_en;
  assign bus.over_en      = r_over_en;
  assign bus.finish_en    = r_finish_en;
  assign bus.move_en      = r_move_en;
  assign bus.refresh_tick = w_refresh_tick;
  assign bus.lives_left   = r_lives;
  assign bus.distance     = r_distance;

endmodule
